fc_tile_scheduler: RTL and testbench

//  Sequencer for one fully-connected layer built from PO parallel MAC lanes.
//  - Streams input neurons from the dual-port input RAM (PI neurons per word, two

---
 rtl/fc_sched_pkg.sv | 40 ++++
 rtl/fc_sched_delay.sv | 30 +++
 rtl/fc_tile_scheduler.sv | 167 ++++++++++++++++
 tb/tb_fc_tile_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_sched_pkg.sv
// Shared types and constants for the fully-connected layer tile scheduler.
// The defaults here size the bench and the top-level parameter defaults.
package fc_sched_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      DRAIN = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } sched_state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   // Zero-width buses are illegal, so a single-valued index still gets one bit.
   function automatic int width_of(input int value);
      return (clog2(value) < 1) ? 1 : clog2(value);
   endfunction

   localparam int DEF_INNEURON  = 16;
   localparam int DEF_OUTNEURON = 8;
   localparam int DEF_PI        = 4;
   localparam int DEF_PO        = 4;
   localparam int DEF_MULT_LAT  = 2;
   localparam int RAM_LAT       = 1;

   localparam int N        = DEF_INNEURON / 2;
   localparam int T        = DEF_OUTNEURON / DEF_PO;
   localparam int TILE_CYC = N + DEF_MULT_LAT + 2;

endpackage

// File: rtl/fc_sched_delay.sv
// Enable-gated shift register with asynchronous active-low clear; aligns
// issue-cycle control to the data coming back from the synchronous RAMs.
module fc_sched_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

   // Shift only while the datapath advances so a stall freezes alignment.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pipe <= '0;
      end else if (i_en) begin
         r_pipe[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/fc_tile_scheduler.sv
// Sequencer for one fully-connected layer: streams input neurons and weights
// through PO MAC lanes, one output tile at a time, then writes each tile out.
module fc_tile_scheduler
   import fc_sched_pkg::*;
#(
   parameter int INNEURON  = DEF_INNEURON,
   parameter int OUTNEURON = DEF_OUTNEURON,
   parameter int PI        = DEF_PI,
   parameter int PO        = DEF_PO,
   parameter int MULT_LAT  = DEF_MULT_LAT,
   parameter int IN_AW     = width_of(INNEURON / PI),
   parameter int W_AW      = width_of(INNEURON * OUTNEURON / PO),
   parameter int OUT_AW    = width_of(OUTNEURON / PO),
   parameter int LANE_W    = width_of(PI)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [IN_AW-1:0]  in_addra,
   output logic [IN_AW-1:0]  in_addrb,
   output logic              in_rden,
   output logic [LANE_W-1:0] lane_sel_a,
   output logic [LANE_W-1:0] lane_sel_b,
   output logic [W_AW-1:0]   w_addra,
   output logic [W_AW-1:0]   w_addrb,
   output logic              w_rden,
   output logic              accum_sload,
   output logic              enable_mult,
   output logic              wr_en,
   output logic [OUT_AW-1:0] wr_addr
);

   localparam int N_ISS   = INNEURON / 2;
   localparam int T_TILES = OUTNEURON / PO;
   localparam int K_W     = width_of(N_ISS);
   localparam int D_W     = width_of(MULT_LAT + 1);
   localparam int PIPE_W  = 2 + 2 * LANE_W;

   sched_state_t      r_state;
   sched_state_t      w_state_nxt;
   logic [K_W-1:0]    r_k;
   logic [K_W-1:0]    w_k_nxt;
   logic [OUT_AW-1:0] r_tile;
   logic [OUT_AW-1:0] w_tile_nxt;
   logic [D_W-1:0]    r_drain;
   logic [D_W-1:0]    w_drain_nxt;
   logic              w_issue;
   logic [31:0]       w_two_k;
   logic [PIPE_W-1:0] w_pipe_d;
   logic [PIPE_W-1:0] w_pipe_q;

   // State and loop counters; everything holds while enable is low.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_k     <= '0;
         r_tile  <= '0;
         r_drain <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_k     <= w_k_nxt;
         r_tile  <= w_tile_nxt;
         r_drain <= w_drain_nxt;
      end
   end

   // Next-state and counter update.
   always_comb begin
      w_state_nxt = r_state;
      w_k_nxt     = r_k;
      w_tile_nxt  = r_tile;
      w_drain_nxt = r_drain;
      if (enable) begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  w_state_nxt = ISSUE;
                  w_k_nxt     = '0;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
            ISSUE: begin
               if (r_k == K_W'(N_ISS - 1)) begin
                  w_k_nxt     = '0;
                  w_drain_nxt = '0;
                  w_state_nxt = DRAIN;
               end else begin
                  w_k_nxt = r_k + K_W'(1);
               end
            end
            DRAIN: begin
               // One cycle for the RAM read plus the multiplier pipeline.
               if (r_drain == D_W'(MULT_LAT)) begin
                  w_drain_nxt = '0;
                  w_state_nxt = WRITE;
               end else begin
                  w_drain_nxt = r_drain + D_W'(1);
               end
            end
            WRITE: begin
               if (r_tile == OUT_AW'(T_TILES - 1)) begin
                  w_state_nxt = DONE;
               end else begin
                  w_tile_nxt  = r_tile + OUT_AW'(1);
                  w_state_nxt = ISSUE;
               end
            end
            DONE: begin
               w_tile_nxt  = '0;
               w_state_nxt = IDLE;
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end else begin
         w_state_nxt = r_state;
      end
   end

   // Issue-cycle addresses; forced to zero outside ISSUE so idle outputs are clean.
   always_comb begin
      w_issue  = (r_state == ISSUE);
      w_two_k  = 32'(r_k) * 32'd2;
      in_addra = '0;
      in_addrb = '0;
      w_addra  = '0;
      w_addrb  = '0;
      w_pipe_d = '0;
      if (w_issue) begin
         in_addra = IN_AW'(w_two_k / PI);
         in_addrb = IN_AW'((w_two_k + 32'd1) / PI);
         w_addra  = W_AW'(32'(r_tile) * INNEURON + w_two_k);
         w_addrb  = W_AW'(32'(r_tile) * INNEURON + w_two_k + 32'd1);
         w_pipe_d = {1'b1, (r_k == '0), LANE_W'(w_two_k % PI), LANE_W'((w_two_k + 32'd1) % PI)};
      end else begin
         w_pipe_d = '0;
      end
   end

   fc_sched_delay #(
      .WIDTH (PIPE_W),
      .DEPTH (RAM_LAT)
   ) u_delay (
      .i_clk   (clock),
      .i_rst_n (reset),
      .i_en    (enable),
      .i_d     (w_pipe_d),
      .o_q     (w_pipe_q)
   );

   assign in_rden     = w_issue;
   assign w_rden      = w_issue;
   assign busy        = (r_state == ISSUE) || (r_state == DRAIN) || (r_state == WRITE);
   assign done        = (r_state == DONE);
   assign wr_en       = (r_state == WRITE) && enable;
   assign wr_addr     = (r_state == WRITE) ? r_tile : '0;
   assign enable_mult = w_pipe_q[PIPE_W-1] && enable;
   assign accum_sload = w_pipe_q[PIPE_W-2];
   assign lane_sel_a  = w_pipe_q[2*LANE_W-1:LANE_W];
   assign lane_sel_b  = w_pipe_q[LANE_W-1:0];

endmodule

// File: tb/tb_fc_tile_scheduler.sv
// Self-checking bench: a position-in-run model predicts every output each
// cycle; directed runs add literal timing pins, then random enable/start/reset.
module tb_fc_tile_scheduler;
   import fc_sched_pkg::*;

   localparam int IN_AW  = width_of(DEF_INNEURON / DEF_PI);
   localparam int W_AW   = width_of(DEF_INNEURON * DEF_OUTNEURON / DEF_PO);
   localparam int OUT_AW = width_of(DEF_OUTNEURON / DEF_PO);
   localparam int LANE_W = width_of(DEF_PI);
   localparam int TOTAL  = T * TILE_CYC;

   typedef struct packed {
      logic        busy, done, rden, wr_en, em, sload;
      logic [31:0] ina, inb, wa, wb, wra, la, lb;
   } exp_t;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              enable = 1'b1;
   logic              start = 1'b0;
   logic              busy, done, in_rden, w_rden, accum_sload, enable_mult, wr_en;
   logic [IN_AW-1:0]  in_addra, in_addrb;
   logic [LANE_W-1:0] lane_sel_a, lane_sel_b;
   logic [W_AW-1:0]   w_addra, w_addrb;
   logic [OUT_AW-1:0] wr_addr;

   int   n_checks = 0;
   int   n_errors = 0;
   logic m_active = 1'b0;
   int   m_pos = 0;
   exp_t m_exp;

   fc_tile_scheduler dut (
      .clock(clock), .reset(reset), .enable(enable), .start(start),
      .busy(busy), .done(done), .in_addra(in_addra), .in_addrb(in_addrb),
      .in_rden(in_rden), .lane_sel_a(lane_sel_a), .lane_sel_b(lane_sel_b),
      .w_addra(w_addra), .w_addrb(w_addrb), .w_rden(w_rden),
      .accum_sload(accum_sload), .enable_mult(enable_mult),
      .wr_en(wr_en), .wr_addr(wr_addr)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Outputs as a function of "how many enabled cycles since start was accepted".
   function automatic exp_t model_out(input logic act, input int pos, input logic en);
      exp_t e;
      int t, j, jj;
      e = '0;
      if (act) begin
         if (pos < TOTAL) begin
            e.busy = 1'b1;
            t = pos / TILE_CYC;
            j = pos % TILE_CYC;
            if (j < N) begin
               e.rden = 1'b1;
               e.ina  = 32'((2 * j) / DEF_PI);
               e.inb  = 32'((2 * j + 1) / DEF_PI);
               e.wa   = 32'(t * DEF_INNEURON + 2 * j);
               e.wb   = e.wa + 32'd1;
            end
            if (j == TILE_CYC - 1) begin
               e.wr_en = en;
               e.wra   = 32'(t);
            end
         end else begin
            e.done = 1'b1;
         end
         if (pos >= 1) begin
            jj = (pos - 1) % TILE_CYC;
            if (jj < N) begin
               e.em    = en;
               e.sload = (jj == 0);
               e.la    = 32'((2 * jj) % DEF_PI);
               e.lb    = 32'((2 * jj + 1) % DEF_PI);
            end
         end
      end
      return e;
   endfunction

   // Reference model position tracker.
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_active <= 1'b0;
         m_pos    <= 0;
      end else if (enable) begin
         if (!m_active) begin
            if (start) begin
               m_active <= 1'b1;
               m_pos    <= 0;
            end
         end else if (m_pos == TOTAL) begin
            m_active <= 1'b0;
         end else begin
            m_pos <= m_pos + 1;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clock) begin
      m_exp = model_out(m_active, m_pos, enable);
      chk("busy", 32'(busy), 32'(m_exp.busy));
      chk("done", 32'(done), 32'(m_exp.done));
      chk("in_rden", 32'(in_rden), 32'(m_exp.rden));
      chk("w_rden", 32'(w_rden), 32'(m_exp.rden));
      chk("in_addra", 32'(in_addra), m_exp.ina);
      chk("in_addrb", 32'(in_addrb), m_exp.inb);
      chk("w_addra", 32'(w_addra), m_exp.wa);
      chk("w_addrb", 32'(w_addrb), m_exp.wb);
      chk("wr_en", 32'(wr_en), 32'(m_exp.wr_en));
      chk("wr_addr", 32'(wr_addr), m_exp.wra);
      chk("enable_mult", 32'(enable_mult), 32'(m_exp.em));
      chk("accum_sload", 32'(accum_sload), 32'(m_exp.sload));
      chk("lane_sel_a", 32'(lane_sel_a), m_exp.la);
      chk("lane_sel_b", 32'(lane_sel_b), m_exp.lb);
   end

   // mode 1 adds literal pins for the plain run, mode 2 for the stall window.
   task automatic run_test(input int mode, input int stall_from, input int stall_len,
                           input int extra_start, input int exp_done);
      int first_done;
      int n_done;
      int ina_seq[8];
      int lane_seq[8];
      ina_seq  = '{0, 0, 1, 1, 2, 2, 3, 3};
      lane_seq = '{0, 2, 0, 2, 0, 2, 0, 2};
      first_done = -1;
      n_done = 0;
      start = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         tick;
         start  = (c == extra_start);
         enable = !(c >= stall_from && c < stall_from + stall_len);
         #2;
         if (done) begin
            n_done++;
            if (first_done < 0) first_done = c;
         end
         if (mode == 1) begin
            if (c >= 1 && c <= 8) chk("pin_in_addra_seq", 32'(in_addra), 32'(ina_seq[c-1]));
            if (c >= 2 && c <= 9) chk("pin_lane_a_seq", 32'(lane_sel_a), 32'(lane_seq[c-2]));
            if (c == 2 || c == 14) chk("pin_sload", 32'(accum_sload), 32'd1);
            if (c == 12 || c == 24) chk("pin_wr_en", 32'(wr_en), 32'd1);
            if (c == 12) chk("pin_wr_addr0", 32'(wr_addr), 32'd0);
            if (c == 24) chk("pin_wr_addr1", 32'(wr_addr), 32'd1);
            if (c == 13) chk("pin_t1_w_addra", 32'(w_addra), 32'd16);
            if (c == 13) chk("pin_t1_w_addrb", 32'(w_addrb), 32'd17);
            if (c == 20) chk("pin_t1_last_w_addra", 32'(w_addra), 32'd30);
         end
         if (mode == 2 && c >= stall_from && c < stall_from + stall_len) begin
            chk("pin_stall_emult", 32'(enable_mult), 32'd0);
            chk("pin_stall_in_addra", 32'(in_addra), 32'd2);
         end
      end
      chk("done_cycle", 32'(first_done), 32'(exp_done));
      chk("done_count", 32'(n_done), 32'd1);
      enable = 1'b1;
      start  = 1'b0;
   endtask

   initial begin
      int first_done;
      int second_done;
      int n_bad;
      reset = 1'b0;
      repeat (3) tick;
      reset = 1'b1;
      repeat (2) tick;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_w_addrb", 32'(w_addrb), 32'd0);
      chk("reset_wr_en", 32'(wr_en), 32'd0);

      run_test(1, -1, 0, -1, 25);
      run_test(2, 5, 3, -1, 28);
      run_test(0, -1, 0, 5, 25);

      // Reset in the middle of tile 0.
      start = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         tick;
         start = 1'b0;
      end
      reset = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_in_rden", 32'(in_rden), 32'd0);
      chk("midrst_w_addra", 32'(w_addra), 32'd0);
      chk("midrst_emult", 32'(enable_mult), 32'd0);
      chk("midrst_lane_b", 32'(lane_sel_b), 32'd0);
      repeat (2) tick;
      reset = 1'b1;
      n_bad = 0;
      for (int c = 0; c < 20; c++) begin
         tick;
         #2;
         if (wr_en || done) n_bad++;
      end
      chk("midrst_no_wr_done", 32'(n_bad), 32'd0);
      run_test(0, -1, 0, -1, 25);

      // Back-to-back: restart on the cycle after done.
      first_done = -1;
      second_done = -1;
      start = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         tick;
         start = (c == 26);
         #2;
         if (done && first_done < 0) first_done = c;
         else if (done && second_done < 0) second_done = c;
         if (c == 38) chk("b2b_wr_addr0", 32'(wr_addr), 32'd0);
         if (c == 38) chk("b2b_wr_en", 32'(wr_en), 32'd1);
      end
      chk("b2b_done1", 32'(first_done), 32'd25);
      chk("b2b_done2", 32'(second_done), 32'd51);
      start = 1'b0;

      // Random enable, start and occasional asynchronous reset.
      for (int i = 0; i < 1500; i++) begin
         tick;
         enable = ($urandom_range(0, 7) != 0);
         start  = ($urandom_range(0, 15) == 0);
         reset  = ($urandom_range(0, 299) != 0);
      end
      reset = 1'b1;
      start = 1'b0;
      enable = 1'b1;
      repeat (40) tick;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
